// File: rtl/mem_wb_stage.sv
// Memory-access stage with request/ack handshake, timeout abort and MEM/WB register.
// Optional store-data forwarding from the MEM/WB register: define MEMWB_STFWD_EN.
module mem_wb_stage #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              PCS,
    input  logic              HALT,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic [REG_W-1:0]  Rt,
    input  logic [REG_W-1:0]  Rd,
    input  logic [DATA_W-1:0] PC_Inc,
    input  logic [DATA_W-1:0] dataRt,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              stall,
    output logic              mem_err,
    output logic              RegWrite_Out,
    output logic              HALT_Out,
    output logic [REG_W-1:0]  Rd_Out,
    output logic [DATA_W-1:0] wb_data
);

    localparam int unsigned       CNT_W    = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic                r_lat_wr;
    logic                r_lat_ld;
    logic [DATA_W-1:0]   r_lat_addr;
    logic [DATA_W-1:0]   r_lat_wdata;

    logic                r_m2r;
    logic                r_pcs;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_access;
    logic [DATA_W-1:0]   w_st_data;
    logic                w_req;
    logic                w_wr;
    logic [DATA_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_stall;
    logic                w_abort;
    logic                w_ld_done;
    logic                w_latch;

    assign w_access = MemRead | MemWrite;

`ifdef MEMWB_STFWD_EN
    // Load-then-store of the same register: take the value about to be written back.
    assign w_st_data = (MemWrite && RegWrite_Out && (Rd_Out == Rt) && (Rd_Out != '0))
                       ? wb_data : dataRt;
`else
    logic w_unused_rt;
    assign w_unused_rt = ^Rt;
    assign w_st_data   = dataRt;
`endif

    // State and wait counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_access && !mem_valid) begin
                    w_next_state = S_WAIT;
                    w_cnt_nxt    = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (mem_valid) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt < CNT_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request, stall and retire-control decode
    always_comb begin
        w_req     = 1'b0;
        w_wr      = 1'b0;
        w_addr    = ALU_Out;
        w_wdata   = w_st_data;
        w_stall   = 1'b0;
        w_abort   = 1'b0;
        w_ld_done = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_req     = 1'b1;
                    w_wr      = MemWrite;
                    w_latch   = 1'b1;
                    w_stall   = !mem_valid;
                    w_ld_done = mem_valid && !MemWrite;
                end
            end
            S_WAIT: begin
                w_req   = 1'b1;
                w_wr    = r_lat_wr;
                w_addr  = r_lat_addr;
                w_wdata = r_lat_wdata;
                if (mem_valid) begin
                    w_ld_done = r_lat_ld;
                end else if (r_cnt < CNT_LAST) begin
                    w_stall = 1'b1;
                end else begin
                    w_abort = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset must kill an in-flight request in the same instant
    assign mem_req   = w_req & ~rst_n;
    assign mem_wr    = w_wr & ~rst_n;
    assign stall     = w_stall & ~rst_n;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;

    // Request copy held stable for the whole access
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_lat_wr    <= 1'b0;
            r_lat_ld    <= 1'b0;
            r_lat_addr  <= '0;
            r_lat_wdata <= '0;
        end else if (w_latch) begin
            r_lat_wr    <= MemWrite;
            r_lat_ld    <= !MemWrite;
            r_lat_addr  <= ALU_Out;
            r_lat_wdata <= w_st_data;
        end
    end

    // MEM/WB register: bubble while stalled, forced halt on timeout
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            RegWrite_Out <= 1'b0;
            HALT_Out     <= 1'b0;
            Rd_Out       <= '0;
            r_m2r        <= 1'b0;
            r_pcs        <= 1'b0;
            r_alu        <= '0;
            r_pc         <= '0;
            r_rdata      <= '0;
        end else if (w_stall) begin
            RegWrite_Out <= 1'b0;
            HALT_Out     <= 1'b0;
        end else begin
            RegWrite_Out <= RegWrite & ~w_abort;
            HALT_Out     <= HALT | w_abort;
            Rd_Out       <= Rd;
            r_m2r        <= MemtoReg;
            r_pcs        <= PCS;
            r_alu        <= ALU_Out;
            r_pc         <= PC_Inc;
            if (w_ld_done) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mem_err <= 1'b0;
        end else if (w_abort) begin
            mem_err <= 1'b1;
        end
    end

    assign wb_data = r_pcs ? r_pc : (r_m2r ? r_rdata : r_alu);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, reset corner cases, randomized run vs. model.
module tb_mem_wb_stage;

    localparam int NEVER = 255;
    localparam int TMO   = 15;
`ifdef MEMWB_STFWD_EN
    localparam logic [15:0] FWD_EXP = 16'h5555;
`else
    localparam logic [15:0] FWD_EXP = 16'h0000;
`endif

    typedef struct {
        logic        rd_en, wr_en, rw, m2r, pcs, halt;
        logic [15:0] alu;
        logic [3:0]  rt, rd;
        logic [15:0] pc, drt;
    } instr_t;

    typedef struct {
        instr_t      in;
        int          lat;
        logic [15:0] rdata;
        int          stalls;
        logic [15:0] wdata;
        logic        rw, halt;
        logic [3:0]  rd;
        logic [15:0] wb;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 0, MemWrite = 0, RegWrite = 0, MemtoReg = 0, PCS = 0, HALT = 0;
    logic [15:0] ALU_Out = '0, PC_Inc = '0, dataRt = '0, mem_rdata = '0;
    logic [3:0]  Rt = '0, Rd = '0;
    logic        mem_valid = 0;
    logic        mem_req, mem_wr, stall, mem_err, RegWrite_Out, HALT_Out;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  Rd_Out;

    int n_chk = 0;
    int n_pass = 0;

    // Model state: last retired record, held read data, sticky error
    logic        m_rw, m_err;
    logic [3:0]  m_rd;
    logic [15:0] m_wb, m_rdata;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .PCS(PCS), .HALT(HALT), .ALU_Out(ALU_Out), .Rt(Rt), .Rd(Rd), .PC_Inc(PC_Inc),
        .dataRt(dataRt), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall(stall),
        .mem_err(mem_err), .RegWrite_Out(RegWrite_Out), .HALT_Out(HALT_Out),
        .Rd_Out(Rd_Out), .wb_data(wb_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic instr_t mk_in(input logic r, w, rw, m2r, pcs, halt,
                                     input logic [15:0] alu, input logic [3:0] rt, rd,
                                     input logic [15:0] pc, drt);
        instr_t t;
        t.rd_en = r; t.wr_en = w; t.rw = rw; t.m2r = m2r; t.pcs = pcs; t.halt = halt;
        t.alu = alu; t.rt = rt; t.rd = rd; t.pc = pc; t.drt = drt;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        MemRead = t.rd_en; MemWrite = t.wr_en; RegWrite = t.rw; MemtoReg = t.m2r;
        PCS = t.pcs; HALT = t.halt; ALU_Out = t.alu; Rt = t.rt; Rd = t.rd;
        PC_Inc = t.pc; dataRt = t.drt;
    endtask

    task automatic clear_inputs();
        drive(mk_in(0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 4'h0, 16'h0, 16'h0));
        mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        m_rw = 0; m_err = 0; m_rd = '0; m_wb = '0; m_rdata = '0;
    endtask

    // One instruction, starting at a negedge; ends at the negedge after it retires
    task automatic run_instr(input instr_t t, input int lat, input logic [15:0] rdata,
                             input int exp_stalls, input logic [15:0] exp_wdata,
                             input logic exp_rw, exp_halt, input logic [3:0] exp_rd,
                             input logic [15:0] exp_wb, input logic exp_err);
        logic acc;
        acc = t.rd_en | t.wr_en;
        for (int k = 0; k <= exp_stalls; k++) begin
            drive(t);
            mem_valid = acc ? (k == lat) : 1'($urandom_range(0, 1));
            mem_rdata = (acc && k == lat) ? rdata : 16'($urandom);
            #1;
            check("mem_req", mem_req, acc);
            check("stall", stall, k < exp_stalls);
            if (acc) begin
                check("mem_wr", mem_wr, t.wr_en);
                check("mem_addr", mem_addr, t.alu);
                if (t.wr_en) check("mem_wdata", mem_wdata, exp_wdata);
            end
            @(posedge clk);
            @(negedge clk);
            if (k < exp_stalls) begin
                check("bubble_rw", RegWrite_Out, 1'b0);
                check("bubble_halt", HALT_Out, 1'b0);
            end else begin
                check("ret_rw", RegWrite_Out, exp_rw);
                check("ret_halt", HALT_Out, exp_halt);
                check("ret_rd", Rd_Out, exp_rd);
                check("wb_data", wb_data, exp_wb);
                check("mem_err", mem_err, exp_err);
            end
        end
    endtask

    // Model: derive stall count and retire record from the transaction-level rules
    task automatic model_run(input instr_t t, input int lat);
        logic acc, ld, tmo, rw, halt;
        logic [15:0] wd, rdata, wb;
        int stalls;
        acc    = t.rd_en | t.wr_en;
        ld     = t.rd_en & ~t.wr_en;
        tmo    = acc && (lat > TMO - 1);
        stalls = !acc ? 0 : (tmo ? TMO - 1 : lat);
        wd     = t.drt;
`ifdef MEMWB_STFWD_EN
        if (m_rw && m_rd == t.rt && m_rd != 4'd0) wd = m_wb;
`endif
        rdata = 16'($urandom);
        if (acc && ld && !tmo) m_rdata = rdata;
        rw   = tmo ? 1'b0 : t.rw;
        halt = tmo ? 1'b1 : t.halt;
        wb   = t.pcs ? t.pc : (t.m2r ? m_rdata : t.alu);
        m_err = m_err | tmo;
        run_instr(t, lat, rdata, stalls, wd, rw, halt, t.rd, wb, m_err);
        m_rw = rw; m_rd = t.rd; m_wb = wb;
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{mk_in(0,0,1,0,0,0,16'h1234,4'd0,4'd3,16'h0002,16'h0000), 0, 16'h0000, 0, 16'h0000, 1, 0, 4'd3, 16'h1234, 0};
        tbl[1]  = '{mk_in(1,0,1,1,0,0,16'h0040,4'd0,4'd5,16'h0004,16'h0000), 3, 16'hBEEF, 3, 16'h0000, 1, 0, 4'd5, 16'hBEEF, 0};
        tbl[2]  = '{mk_in(0,1,0,0,0,0,16'h0080,4'd7,4'd0,16'h0006,16'h00AA), 0, 16'hDEAD, 0, 16'h00AA, 0, 0, 4'd0, 16'h0080, 0};
        tbl[3]  = '{mk_in(0,0,1,0,1,0,16'h3333,4'd0,4'd2,16'h0100,16'h0000), 0, 16'h0000, 0, 16'h0000, 1, 0, 4'd2, 16'h0100, 0};
        tbl[4]  = '{mk_in(0,0,1,1,0,0,16'h4444,4'd0,4'd4,16'h0102,16'h0000), 0, 16'h0000, 0, 16'h0000, 1, 0, 4'd4, 16'hBEEF, 0};
        tbl[5]  = '{mk_in(1,1,1,1,0,0,16'h0050,4'd1,4'd6,16'h0104,16'h0777), 1, 16'h1111, 1, 16'h0777, 1, 0, 4'd6, 16'hBEEF, 0};
        tbl[6]  = '{mk_in(1,0,1,1,0,0,16'h0060,4'd0,4'd5,16'h0106,16'h0000), 1, 16'h5555, 1, 16'h0000, 1, 0, 4'd5, 16'h5555, 0};
        tbl[7]  = '{mk_in(0,1,0,0,0,0,16'h0070,4'd5,4'd0,16'h0108,16'h0000), 0, 16'h0000, 0, FWD_EXP,   0, 0, 4'd0, 16'h0070, 0};
        tbl[8]  = '{mk_in(0,0,1,0,0,0,16'h9999,4'd0,4'd0,16'h010A,16'h0000), 0, 16'h0000, 0, 16'h0000, 1, 0, 4'd0, 16'h9999, 0};
        tbl[9]  = '{mk_in(0,1,0,0,0,0,16'h0090,4'd0,4'd0,16'h010C,16'h0ABC), 2, 16'h0000, 2, 16'h0ABC, 0, 0, 4'd0, 16'h0090, 0};
        tbl[10] = '{mk_in(1,0,1,1,0,0,16'h00A0,4'd0,4'd8,16'h010E,16'h0000), 14, 16'hCAFE, 14, 16'h0000, 1, 0, 4'd8, 16'hCAFE, 0};
        tbl[11] = '{mk_in(1,0,1,1,0,0,16'h00B0,4'd0,4'd9,16'h0110,16'h0000), NEVER, 16'h0000, 14, 16'h0000, 0, 1, 4'd9, 16'hCAFE, 1};
        tbl[12] = '{mk_in(0,0,1,0,0,0,16'h7777,4'd0,4'd10,16'h0112,16'h0000), 0, 16'h0000, 0, 16'h0000, 1, 0, 4'd10, 16'h7777, 1};

        do_reset();
        rst_n = 1'b1;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_rw", RegWrite_Out, 0);
        check("rst_halt", HALT_Out, 0);
        check("rst_rd", Rd_Out, 0);
        check("rst_wb", wb_data, 0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int i = 0; i < 13; i++)
            run_instr(tbl[i].in, tbl[i].lat, tbl[i].rdata, tbl[i].stalls, tbl[i].wdata,
                      tbl[i].rw, tbl[i].halt, tbl[i].rd, tbl[i].wb, tbl[i].err);

        // Reset in IDLE right after a retire clears MEM/WB and the sticky error at once
        run_instr(mk_in(0,0,1,0,0,0,16'h1234,4'd0,4'd3,16'h0002,16'h0000), 0, 16'h0, 0, 16'h0,
                  1, 0, 4'd3, 16'h1234, 1);
        #2 rst_n = 1'b1;
        #1;
        check("async_rst_rw", RegWrite_Out, 0);
        check("async_rst_rd", Rd_Out, 0);
        check("async_rst_wb", wb_data, 0);
        check("async_rst_err", mem_err, 0);
        @(negedge clk);
        rst_n = 1'b0;

        // Reset in the middle of WAIT with the load still presented
        drive(mk_in(1,0,1,1,0,0,16'h0040,4'd0,4'd5,16'h0004,16'h0000));
        mem_valid = 1'b0;
        repeat (3) begin
            #1 check("pre_wait_stall", stall, 1);
            @(negedge clk);
        end
        #1 check("wait_req", mem_req, 1);
        #1 rst_n = 1'b1;
        #1;
        check("midwait_req", mem_req, 0);
        check("midwait_stall", stall, 0);
        check("midwait_rw", RegWrite_Out, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("post_rst_err", mem_err, 0);
        // A full timeout now proves the FSM restarted from IDLE with a clear counter
        run_instr(mk_in(1,0,1,1,0,0,16'h0040,4'd0,4'd5,16'h0004,16'h0000), NEVER, 16'h0, 14, 16'h0,
                  0, 1, 4'd5, 16'h0000, 1);

        do_reset();
        for (int i = 0; i < 250; i++) begin
            instr_t t;
            int lat, sel;
            t.rd_en = 1'($urandom_range(0, 1));
            t.wr_en = 1'($urandom_range(0, 2) == 0);
            t.rw    = 1'($urandom_range(0, 1));
            t.m2r   = 1'($urandom_range(0, 1));
            t.pcs   = 1'($urandom_range(0, 4) == 0);
            t.halt  = 1'($urandom_range(0, 9) == 0);
            t.alu   = 16'($urandom);
            t.rd    = 4'($urandom);
            t.rt    = $urandom_range(0, 1) ? m_rd : 4'($urandom);
            t.pc    = 16'($urandom);
            t.drt   = 16'($urandom);
            sel = $urandom_range(0, 24);
            lat = (sel == 0) ? NEVER : (sel == 1) ? 14 : $urandom_range(0, 4);
            model_run(t, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes that register's outputs.
- Drives a single-port data-memory request/acknowledge interface and raises a pipeline stall while an access is outstanding.
- Registers the retiring instruction into the MEM/WB register.
- Produces the final writeback data and destination for the register file.

Parameters:
- DATA_W, 16, width of data, addresses and PC values.
- REG_W, 4, register-specifier width.
- TIMEOUT_CYC, 15, maximum cycles waited for mem_valid before the access is aborted (legal range 2..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-high: 1 = reset asserted.
- MemRead  in  1  load in the MEM stage.
- MemWrite  in  1  store in the MEM stage.
- RegWrite  in  1  instruction writes the register file.
- MemtoReg  in  1  writeback selects memory data.
- PCS  in  1  writeback selects PC_Inc.
- HALT  in  1  halt instruction.
- ALU_Out  in  DATA_W  address or ALU result.
- Rt  in  REG_W  store-data source register.
- Rd  in  REG_W  destination register.
- PC_Inc  in  DATA_W  PC+2 of the instruction.
- dataRt  in  DATA_W  store data.
- mem_req  out  1  memory request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid when mem_valid=1.
- mem_valid  in  1  access complete.
- stall  out  1  hold all upstream pipeline registers and the PC.
- mem_err  out  1  sticky timeout error flag.
- RegWrite_Out  out  1  MEM/WB register.
- HALT_Out  out  1  MEM/WB register.
- Rd_Out  out  REG_W  MEM/WB register.
- wb_data  out  DATA_W  writeback value.

Behaviour:
- Reset is asynchronous and immediate:
  - FSM goes to IDLE and the counter clears.
  - mem_req, mem_wr, stall, mem_err, RegWrite_Out and HALT_Out all go to 0.
  - Rd_Out and all internal data registers go to 0, so wb_data reads 0.
- A reset during WAIT drops mem_req in the same instant and abandons the access.
- FSM states are IDLE and WAIT.
- Access definition: access = MemRead | MemWrite.
  - If both are 1, the access is treated as a write and the read is suppressed.
- IDLE with access:
  - mem_req=1 combinationally.
  - mem_wr=MemWrite, mem_addr=ALU_Out, mem_wdata=dataRt (store data, see optional feature).
  - Request fields are latched into internal registers at the edge.
  - If mem_valid=1 in the same cycle, this is a zero-wait completion: stall=0, the instruction retires at the edge and the FSM stays in IDLE.
  - Otherwise stall=1 and the FSM goes to WAIT with the counter set to 1.
- WAIT:
  - mem_req=1 and all request fields come from the latched copy, stable until completion.
  - On mem_valid=1: stall=0, the instruction retires with mem_rdata at the edge, and the FSM returns to IDLE.
  - On mem_valid=0 with counter < TIMEOUT_CYC-1: stall=1 and the counter increments.
  - On mem_valid=0 with counter = TIMEOUT_CYC-1: timeout abort.
    - stall=0 and mem_err is set (sticky until reset).
    - The instruction retires with RegWrite forced to 0 and HALT forced to 1.
    - The FSM goes to IDLE.
- IDLE with no access: stall=0 and the instruction retires every cycle.
  - mem_valid is ignored.
- While stall=1, the MEM/WB register loads a bubble: RegWrite_Out=0 and HALT_Out=0, other fields hold.
  - This guarantees exactly one writeback per instruction.
- Retire captures RegWrite, HALT, Rd, MemtoReg, PCS, ALU_Out, PC_Inc and the read data (mem_rdata on a load, else held).
- wb_data is combinational from the MEM/WB registers:
  - PC_Inc if PCS=1;
  - else read data if MemtoReg=1;
  - else ALU_Out.
- Load latency is one edge after the mem_valid cycle: wb_data is valid in the cycle following completion.

Optional Feature:
- Macro: MEMWB_STFWD_EN.
- Defined: for a store, if RegWrite_Out=1 and Rd_Out==Rt and Rd_Out!=0, then mem_wdata = wb_data; otherwise mem_wdata = dataRt.
  - This covers a load immediately followed by a store of the loaded register.
  - The forwarded value is latched with the request at IDLE.
- Not defined: mem_wdata = dataRt always; the hazard must be resolved upstream.

Test Plan:
- Reset then ALU op (RegWrite=1, Rd=3, ALU_Out=16'h1234), no access -> stall=0; next cycle RegWrite_Out=1, Rd_Out=3, wb_data=16'h1234.
- Load from ALU_Out=16'h0040, mem_valid asserted 3 cycles after mem_req -> mem_req=1, mem_addr=16'h0040, mem_wr=0 for 4 cycles and stall=1 for the first 3; RegWrite_Out=0 during the stall; then one retire with wb_data=mem_rdata=16'hBEEF.
- Zero-wait store (mem_valid=1 in the first cycle, dataRt=16'h00AA) -> mem_wr=1, mem_wdata=16'h00AA, stall never 1, FSM stays in IDLE.
- Load with mem_valid never asserted, TIMEOUT_CYC=15 -> stall=1 for 14 cycles, then mem_err=1 (stays 1), HALT_Out=1, RegWrite_Out=0.
- Assert rst_n=1 mid-WAIT -> mem_req, stall and RegWrite_Out go to 0 immediately; after release, FSM is in IDLE and mem_err=0.
- With MEMWB_STFWD_EN: load r5 (data 16'h5555), then store of Rt=5 with dataRt=16'h0000 -> mem_wdata=16'h5555. Without the macro -> mem_wdata=16'h0000.
